// File: rtl/mac4_pkg.sv
// Shared types and constants for the 4-lane MAC dot-product controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac4_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int MAC_LAT = 4;
   localparam int MAC_C_W = 18;
endpackage

// File: rtl/mac4_dot_ctrl_if.sv
// Job control, operand-buffer read and MAC return signals of the dot-product controller.
// Latency: n/a (wiring only).
// Backpressure: stall is carried from the host to the controller.
interface mac4_dot_ctrl_if
   import mac4_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int ACC_W  = 32
);
   logic               start;
   logic [ADDR_W-1:0]  num_chunks;
   logic               stall;
   logic               rd_en;
   logic [ADDR_W-1:0]  rd_addr;
   logic               mac_valid_in;
   logic [MAC_C_W-1:0] mac_c_out;
   logic               mac_valid_out;
   logic               busy;
   logic               done;
   logic [ACC_W-1:0]   result;
   logic               ovf;

   modport master (
      output start, num_chunks, stall, mac_c_out, mac_valid_out,
      input  rd_en, rd_addr, mac_valid_in, busy, done, result, ovf
   );

   modport slave (
      input  start, num_chunks, stall, mac_c_out, mac_valid_out,
      output rd_en, rd_addr, mac_valid_in, busy, done, result, ovf
   );
endinterface

// File: rtl/mac4_acc.sv
// Signed wrapping accumulator with a sticky overflow flag.
// Latency: next-state outputs are combinational, state updates on the next edge.
// Backpressure: none; add_en is taken every cycle it is high.
module mac4_acc
   import mac4_pkg::*;
#(
   parameter int ACC_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               add_en,
   input  logic [MAC_C_W-1:0] addend,
   output logic [ACC_W-1:0]   acc_nxt,
   output logic               ovf_nxt
);
   logic signed [MAC_C_W-1:0] addend_s;
   logic signed [ACC_W-1:0]   ext;
   logic signed [ACC_W-1:0]   sum;
   logic [ACC_W-1:0]          acc_q;
   logic                      ovf_q;
   logic                      add_ovf;

   assign addend_s = addend;
   assign ext      = ACC_W'(addend_s);
   assign sum      = $signed(acc_q) + ext;
   // Overflow only when both operands share a sign the sum does not.
   assign add_ovf  = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

   always_comb begin
      acc_nxt = acc_q;
      ovf_nxt = ovf_q;
      if (clr) begin
         acc_nxt = '0;
         ovf_nxt = 1'b0;
      end else if (add_en) begin
         acc_nxt = sum;
         ovf_nxt = ovf_q | add_ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_nxt;
         ovf_q <= ovf_nxt;
      end
   end
endmodule

// File: rtl/mac4_dot_ctrl.sv
// Issues N chunk reads to the operand buffer and sums the 4-lane MAC returns.
// Latency: N+6 cycles from start to done without stall (buffer 1, MAC 4).
// Backpressure: stall pauses read issue only; in-flight returns are still summed.
module mac4_dot_ctrl
   import mac4_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   mac4_dot_ctrl_if.slave  bus
);
   state_t            state;
   logic [ADDR_W-1:0] n_q;
   logic [ADDR_W-1:0] iss_cnt;
   logic [ADDR_W-1:0] ret_cnt;
   logic              acc_clr;
   logic              acc_add;
   logic [ACC_W-1:0]  acc_nxt;
   logic              ovf_nxt;

   // Returns only count while a job is live, so stale ones after reset are dropped.
   assign acc_add = ((state == ST_ISSUE) || (state == ST_DRAIN)) && bus.mac_valid_out;
   assign acc_clr = (state == ST_IDLE) && bus.start;

   mac4_acc #(.ACC_W(ACC_W)) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (acc_clr),
      .add_en  (acc_add),
      .addend  (bus.mac_c_out),
      .acc_nxt (acc_nxt),
      .ovf_nxt (ovf_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         n_q              <= '0;
         iss_cnt          <= '0;
         ret_cnt          <= '0;
         bus.rd_en        <= 1'b0;
         bus.rd_addr      <= '0;
         bus.mac_valid_in <= 1'b0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.result       <= '0;
         bus.ovf          <= 1'b0;
      end else begin
         bus.rd_en        <= 1'b0;
         bus.done         <= 1'b0;
         bus.mac_valid_in <= bus.rd_en;
         if (acc_add) begin
            ret_cnt <= ret_cnt + ADDR_W'(1);
         end
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  iss_cnt    <= '0;
                  ret_cnt    <= '0;
                  bus.result <= '0;
                  bus.ovf    <= 1'b0;
                  if (bus.num_chunks == '0) begin
                     state    <= ST_DONE;
                     bus.done <= 1'b1;
                  end else begin
                     n_q      <= bus.num_chunks;
                     state    <= ST_ISSUE;
                     bus.busy <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (!bus.stall) begin
                  bus.rd_en   <= 1'b1;
                  bus.rd_addr <= iss_cnt;
                  iss_cnt     <= iss_cnt + ADDR_W'(1);
                  if (iss_cnt == n_q - ADDR_W'(1)) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Capture the sum including the final return landing on this edge.
               if (acc_add && (ret_cnt + ADDR_W'(1) == n_q)) begin
                  state      <= ST_DONE;
                  bus.done   <= 1'b1;
                  bus.busy   <= 1'b0;
                  bus.result <= acc_nxt;
                  bus.ovf    <= ovf_nxt;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mac4_dot_ctrl.sv
// Randomized bench: models the operand buffer and 4-cycle MAC, checks each job
// against a plain-arithmetic dot-product reference with wrap and overflow.
`timescale 1ns/1ps
module tb_mac4_dot_ctrl;
   import mac4_pkg::*;

   localparam int ADDR_W = 8;
   localparam int ACC_W  = 20;
   localparam int BUDGET = 2000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mac4_dot_ctrl_if #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) mif ();
   mac4_dot_ctrl #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mif)
   );

   int total = 0;
   int bad   = 0;
   int a_mem [256][4];
   int b_mem [256][4];
   int issued [$];
   int mvi_cnt   = 0;
   int last_addr = 0;
   bit pv [MAC_LAT] = '{default: 1'b0};
   int pc [MAC_LAT] = '{default: 0};

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int chunk_dot(input int addr);
      int s = 0;
      for (int j = 0; j < 4; j++) s += a_mem[addr][j] * b_mem[addr][j];
      return s;
   endfunction

   // Reference: running sum of chunk dot products, wrapped to ACC_W bits.
   task automatic model(input int n, output longint res, output bit ov);
      longint span = longint'(1) << ACC_W;
      longint maxv = (longint'(1) << (ACC_W - 1)) - 1;
      longint minv = -(longint'(1) << (ACC_W - 1));
      longint acc  = 0;
      ov = 1'b0;
      for (int k = 0; k < n; k++) begin
         acc += chunk_dot(k);
         if (acc > maxv) begin acc -= span; ov = 1'b1; end
         if (acc < minv) begin acc += span; ov = 1'b1; end
      end
      res = acc;
   endtask

   // Operand buffer (1 cycle) plus MAC pipeline (MAC_LAT cycles), stepped mid-cycle.
   always @(negedge clk) begin
      mif.mac_valid_out = pv[MAC_LAT-1];
      mif.mac_c_out     = 18'(pc[MAC_LAT-1]);
      for (int i = MAC_LAT - 1; i > 0; i--) begin
         pv[i] = pv[i-1];
         pc[i] = pc[i-1];
      end
      pv[0] = mif.mac_valid_in;
      pc[0] = chunk_dot(last_addr);
      if (mif.mac_valid_in) mvi_cnt++;
      if (mif.rd_en) begin
         last_addr = int'(mif.rd_addr);
         issued.push_back(last_addr);
      end
   end

   task automatic fill_rand(input int n);
      for (int k = 0; k < n; k++)
         for (int j = 0; j < 4; j++) begin
            a_mem[k][j] = int'($urandom_range(0, 127)) - 64;
            b_mem[k][j] = int'($urandom_range(0, 127)) - 64;
         end
   endtask

   task automatic fill_const(input int n, input int a0, input int av, input int bv);
      for (int k = 0; k < n; k++)
         for (int j = 0; j < 4; j++) begin
            a_mem[k][j] = (j == 0) ? a0 : av;
            b_mem[k][j] = bv;
         end
   endtask

   // mode 0: no stall, 1: stall toggles each cycle, 2: random stall plus spurious start
   task automatic run_job(input int n, input int mode, input string tag);
      longint exp_res;
      bit     exp_ovf;
      int     cyc;
      bit     ok;
      longint held;
      model(n, exp_res, exp_ovf);
      @(negedge clk);
      issued.delete();
      mvi_cnt        = 0;
      mif.start      = 1'b1;
      mif.num_chunks = ADDR_W'(n);
      mif.stall      = 1'b0;
      @(posedge clk);
      cyc = 0;
      @(negedge clk);
      mif.start = 1'b0;
      check({tag, " busy_after_start"}, mif.busy, (n != 0));
      while (!mif.done && cyc < BUDGET) begin
         case (mode)
            0:       mif.stall = 1'b0;
            1:       mif.stall = ~mif.stall;
            default: begin
               mif.stall      = 1'($urandom_range(0, 1));
               mif.start      = 1'($urandom_range(0, 1));
               mif.num_chunks = ADDR_W'($urandom_range(1, 255));
            end
         endcase
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      mif.start = 1'b0;
      mif.stall = 1'b0;
      check({tag, " done_seen"}, mif.done, 1);
      if (mode == 0) check({tag, " latency"}, cyc, (n == 0) ? 0 : n + 6);
      check({tag, " result"}, longint'($signed(mif.result)), exp_res);
      check({tag, " ovf"}, mif.ovf, exp_ovf);
      check({tag, " busy_at_done"}, mif.busy, 0);
      check({tag, " rd_en_count"}, issued.size(), n);
      ok = 1'b1;
      foreach (issued[i]) if (issued[i] != i) ok = 1'b0;
      check({tag, " rd_addr_order"}, ok, 1);
      check({tag, " mac_valid_in_count"}, mvi_cnt, n);
      held = longint'($signed(mif.result));
      @(negedge clk);
      check({tag, " done_one_cycle"}, mif.done, 0);
      check({tag, " result_held"}, longint'($signed(mif.result)), held);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " rd_en"}, mif.rd_en, 0);
      check({tag, " rd_addr"}, mif.rd_addr, 0);
      check({tag, " mac_valid_in"}, mif.mac_valid_in, 0);
      check({tag, " busy"}, mif.busy, 0);
      check({tag, " done"}, mif.done, 0);
      check({tag, " result"}, mif.result, 0);
      check({tag, " ovf"}, mif.ovf, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n             = 1'b0;
      mif.start         = 1'b0;
      mif.num_chunks    = '0;
      mif.stall         = 1'b0;
      mif.mac_valid_out = 1'b0;
      mif.mac_c_out     = '0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int j = 0; j < 4; j++) begin
         a_mem[0][j] = j + 1;
         b_mem[0][j] = j + 1;
      end
      run_job(1, 0, "n1_dot30");
      check("n1_dot30 literal", longint'($signed(mif.result)), 30);

      fill_const(4, -100, 0, 1);
      run_job(4, 0, "n4_neg100");
      check("n4_neg100 literal", longint'($signed(mif.result)), -400);

      run_job(0, 0, "n0");

      fill_rand(3);
      run_job(3, 1, "n3_stall_toggle");

      fill_const(9, 128, 128, 128);
      run_job(9, 0, "n9_wrap");
      check("n9_wrap literal", longint'($signed(mif.result)), -458752);
      check("n9_wrap ovf_literal", mif.ovf, 1);

      // Reset after two issues; the one return already in the MAC must be dropped.
      fill_rand(8);
      @(negedge clk);
      issued.delete();
      mif.start      = 1'b1;
      mif.num_chunks = ADDR_W'(8);
      @(negedge clk);
      mif.start = 1'b0;
      for (int k = 0; k < 50 && issued.size() < 2; k++) begin
         @(negedge clk);
         #1;
      end
      check("midreset issues_before", issued.size(), 2);
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check_zero_outputs("post_reset_idle");
      fill_rand(5);
      run_job(5, 0, "after_reset");

      for (int t = 0; t < 10; t++) begin
         int n = int'($urandom_range(1, 12));
         fill_rand(n);
         run_job(n, t % 3, $sformatf("rand%0d", t));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mac4_dot_ctrl.md
MAC4_DOT_CTRL -- requirements
Module: mac4_dot_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of chunk address and chunk count.
REQ-002 SHALL have parameter ACC_W, default 32, width of the signed result accumulator (ACC_W >= 18).
REQ-003 SHALL use one clock and an asynchronous active-low reset, as in this list:
 clk  input  1  sole clock, all state updates on rising edge
 rst_n  input  1  asynchronous active-low reset
 start  input  1  begin one dot-product job; sampled only in IDLE
 num_chunks  input  ADDR_W  job length in 4-element chunks, sampled with start
 stall  input  1  freezes new operand issue; in-flight MAC work continues
 rd_en  output  1  operand buffer read strobe; buffer returns a0..a3/b0..b3 one cycle later
 rd_addr  output  ADDR_W  chunk index being read
 mac_valid_in  output  1  valid to the 4-lane MAC; equals rd_en delayed one cycle
 mac_c_out  input  18  signed MAC partial sum
 mac_valid_out  input  1  mac_c_out qualifier
 busy  output  1  high from accepted start until done
 done  output  1  single-cycle completion pulse
 result  output  ACC_W  signed dot product, held from done until next accepted start
 ovf  output  1  sticky signed-overflow flag for current job, held with result

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-005 IDLE: start=1 and num_chunks!=0 SHALL latch N=num_chunks, clear accumulator, ovf, issue and return counters, and go to ISSUE.
REQ-006 IDLE: start=1 and num_chunks==0 SHALL go to DONE with result=0, ovf=0, no rd_en issued.
REQ-007 ISSUE: each cycle with stall=0 SHALL assert rd_en with rd_addr=issue count (0,1,..,N-1), then increment the count; stall=1 SHALL hold rd_en=0 and rd_addr unchanged.
REQ-008 ISSUE SHALL move to DRAIN in the cycle after chunk N-1 is issued; rd_en SHALL never exceed N pulses per job.
REQ-009 mac_valid_in SHALL be rd_en registered once, independent of stall.
REQ-010 Each mac_valid_out=1 while busy SHALL add sign-extended mac_c_out to the accumulator and increment the return count, in every state, including ISSUE.
REQ-011 Accumulator SHALL wrap two's-complement; ovf SHALL set when an add's operands share sign and the sum's sign differs, and SHALL stay set until the next accepted start.
REQ-012 DRAIN SHALL go to DONE on the edge at which the return count reaches N.
REQ-013 DONE SHALL assert done=1 for exactly one cycle, drive the final result, then return to IDLE.
REQ-014 start SHALL be ignored while busy=1; mac_valid_out SHALL be ignored in IDLE.
REQ-015 Latency with no stall SHALL be N+6 cycles from start edge to done (MAC latency 4, buffer latency 1).

Reset
REQ-016 rst_n=0 SHALL immediately force IDLE, rd_en=0, rd_addr=0, mac_valid_in=0, busy=0, done=0, result=0, ovf=0, all counters 0, including mid-job.
REQ-017 MAC returns arriving after a mid-job reset SHALL be ignored.

Structure
REQ-018 A shared package mac4_pkg SHALL hold the FSM state enum, MAC_LAT=4, and MAC_C_W=18.
REQ-019 The accumulator with overflow detection SHALL be one sub-module, mac4_acc.

Verification
REQ-020 N=1, a=(1,2,3,4), b=(1,2,3,4) -> mac_c_out=30; result=30, ovf=0, done in cycle 7 after start.
REQ-021 N=4, every return -100 -> result=-400, exactly 4 rd_en pulses with rd_addr 0..3.
REQ-022 N=0 -> done on the cycle after start, result=0, no rd_en, no mac_valid_in.
REQ-023 N=3, stall toggling every cycle -> rd_addr 0,1,2 each issued once, correct sum, done after the third return.
REQ-024 ACC_W=20, N=9, every return 65536 -> ovf=1, result=589824 wrapped to -458752.
REQ-025 rst_n low in ISSUE after 2 issues, then a pending mac_valid_out -> all outputs 0, result stays 0, next job computes correctly.
